// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle: hazard/memory status from the datapath and the
// hold, flush and status signals returned by pipe_ctrl.
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [2:0]       id_rs;
    logic             id_rs_valid;
    logic [2:0]       id_rt;
    logic             id_rt_valid;
    logic             ex_is_load;
    logic             ex_wr_en;
    logic [2:0]       ex_wr_reg;
    logic             branch_taken;
    logic             dmem_req;
    logic             dmem_done;
    logic             stall_cnt_clr;

    logic             pc_stall_n;
    logic             if_id_stall_n;
    logic             id_ex_stall_n;
    logic             ex_mem_stall_n;
    logic             mem_wb_stall_n;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             busy_wait;
    logic [CNT_W-1:0] stall_cnt;
    logic             err;

    modport master (
        output id_rs, id_rs_valid, id_rt, id_rt_valid,
        output ex_is_load, ex_wr_en, ex_wr_reg, branch_taken,
        output dmem_req, dmem_done, stall_cnt_clr,
        input  pc_stall_n, if_id_stall_n, id_ex_stall_n, ex_mem_stall_n, mem_wb_stall_n,
        input  if_id_flush, id_ex_bubble, busy_wait, stall_cnt, err
    );

    modport slave (
        input  id_rs, id_rs_valid, id_rt, id_rt_valid,
        input  ex_is_load, ex_wr_en, ex_wr_reg, branch_taken,
        input  dmem_req, dmem_done, stall_cnt_clr,
        output pc_stall_n, if_id_stall_n, id_ex_stall_n, ex_mem_stall_n, mem_wb_stall_n,
        output if_id_flush, id_ex_bubble, busy_wait, stall_cnt, err
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard controller: load-use stall, branch flush,
// data-memory wait freeze with timeout to a sticky error, and a stall counter.
module pipe_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    pipe_ctrl_if.slave bus
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR  = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;
    logic              busy_wait_q;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic freeze_s;
    logic hold_all_s;
    logic load_use_s;
    logic any_stall_s;
    logic pc_stall_n_s, if_id_stall_n_s, id_ex_stall_n_s, ex_mem_stall_n_s, mem_wb_stall_n_s;
    logic if_id_flush_s, id_ex_bubble_s;

    function automatic logic load_use_f(
        input logic       is_load,
        input logic       wr_en,
        input logic [2:0] wr_reg,
        input logic       rs_valid,
        input logic [2:0] rs,
        input logic       rt_valid,
        input logic [2:0] rt
    );
        return is_load & wr_en & ((rs_valid & (rs == wr_reg)) | (rt_valid & (rt == wr_reg)));
    endfunction

    assign freeze_s   = bus.dmem_req & ~bus.dmem_done;
    assign hold_all_s = freeze_s | (state_q == ST_ERR);
    assign load_use_s = load_use_f(bus.ex_is_load, bus.ex_wr_en, bus.ex_wr_reg,
                                   bus.id_rs_valid, bus.id_rs, bus.id_rt_valid, bus.id_rt);

    // Hold/flush decode; priority is freeze/error, then branch, then load-use.
    always_comb begin
        pc_stall_n_s     = 1'b1;
        if_id_stall_n_s  = 1'b1;
        id_ex_stall_n_s  = 1'b1;
        ex_mem_stall_n_s = 1'b1;
        mem_wb_stall_n_s = 1'b1;
        if_id_flush_s    = 1'b0;
        id_ex_bubble_s   = 1'b0;
        if (hold_all_s) begin
            pc_stall_n_s     = 1'b0;
            if_id_stall_n_s  = 1'b0;
            id_ex_stall_n_s  = 1'b0;
            ex_mem_stall_n_s = 1'b0;
            mem_wb_stall_n_s = 1'b0;
        end else if (bus.branch_taken) begin
            if_id_flush_s  = 1'b1;
            id_ex_bubble_s = 1'b1;
        end else if (load_use_s) begin
            pc_stall_n_s    = 1'b0;
            if_id_stall_n_s = 1'b0;
            id_ex_bubble_s  = 1'b1;
        end else begin
            if_id_flush_s  = 1'b0;
            id_ex_bubble_s = 1'b0;
        end
    end

    assign any_stall_s = ~(pc_stall_n_s & if_id_stall_n_s & id_ex_stall_n_s &
                           ex_mem_stall_n_s & mem_wb_stall_n_s);

    // Memory-wait FSM next state, wait timer and sticky error.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        case (state_q)
            ST_RUN: begin
                wait_cnt_d = '0;
                if (freeze_s) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_WAIT: begin
                if (bus.dmem_done) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (freeze_s) begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d    = ST_ERR;
                        err_d      = 1'b1;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ERR: begin
                state_d    = ST_ERR;
                err_d      = 1'b1;
                wait_cnt_d = '0;
            end
            default: begin
                // An unreachable encoding is treated as a fault.
                state_d    = ST_ERR;
                err_d      = 1'b1;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Saturating stall counter with clear taking priority.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.stall_cnt_clr) begin
            stall_cnt_d = '0;
        end else if (any_stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State, timers, status flags and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            busy_wait_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            busy_wait_q <= (state_d == ST_WAIT);
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pc_stall_n     = pc_stall_n_s;
    assign bus.if_id_stall_n  = if_id_stall_n_s;
    assign bus.id_ex_stall_n  = id_ex_stall_n_s;
    assign bus.ex_mem_stall_n = ex_mem_stall_n_s;
    assign bus.mem_wb_stall_n = mem_wb_stall_n_s;
    assign bus.if_id_flush    = if_id_flush_s;
    assign bus.id_ex_bubble   = id_ex_bubble_s;
    assign bus.busy_wait      = busy_wait_q;
    assign bus.stall_cnt      = stall_cnt_q;
    assign bus.err            = err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a short timeout and a narrow stall counter.
module tb_pipe_ctrl;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    pipe_ctrl_if #(.CNT_W(4)) bus ();

    pipe_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [4:0] stall_v;
    assign stall_v = {bus.pc_stall_n, bus.if_id_stall_n, bus.id_ex_stall_n,
                      bus.ex_mem_stall_n, bus.mem_wb_stall_n};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_rs         = 3'd0;
        bus.id_rs_valid   = 1'b0;
        bus.id_rt         = 3'd0;
        bus.id_rt_valid   = 1'b0;
        bus.ex_is_load    = 1'b0;
        bus.ex_wr_en      = 1'b0;
        bus.ex_wr_reg     = 3'd0;
        bus.branch_taken  = 1'b0;
        bus.dmem_req      = 1'b0;
        bus.dmem_done     = 1'b0;
        bus.stall_cnt_clr = 1'b0;
    endtask

    task automatic set_load_use();
        bus.ex_is_load  = 1'b1;
        bus.ex_wr_en    = 1'b1;
        bus.ex_wr_reg   = 3'd3;
        bus.id_rs_valid = 1'b1;
        bus.id_rs       = 3'd3;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        clear_inputs();
        #2;
        chk("rst_stall",  32'(stall_v), 32'h1f);
        chk("rst_flush",  32'(bus.if_id_flush), 32'h0);
        chk("rst_bubble", 32'(bus.id_ex_bubble), 32'h0);
        chk("rst_busy",   32'(bus.busy_wait), 32'h0);
        chk("rst_err",    32'(bus.err), 32'h0);
        chk("rst_cnt",    32'(bus.stall_cnt), 32'h0);

        // Outputs still decode while reset is held; counter stays cleared.
        set_load_use();
        #1;
        chk("rst_lu_stall",  32'(stall_v), 32'h07);
        chk("rst_lu_bubble", 32'(bus.id_ex_bubble), 32'h1);
        tick();
        chk("rst_lu_cnt", 32'(bus.stall_cnt), 32'h0);
        clear_inputs();
        rst_n = 1'b1;

        // Load-use on rs.
        set_load_use();
        #1;
        chk("lu_rs_stall",  32'(stall_v), 32'h07);
        chk("lu_rs_bubble", 32'(bus.id_ex_bubble), 32'h1);
        chk("lu_rs_flush",  32'(bus.if_id_flush), 32'h0);
        tick();
        chk("lu_rs_cnt", 32'(bus.stall_cnt), 32'h1);

        // Branch overrides load-use.
        bus.branch_taken = 1'b1;
        #1;
        chk("br_stall",  32'(stall_v), 32'h1f);
        chk("br_flush",  32'(bus.if_id_flush), 32'h1);
        chk("br_bubble", 32'(bus.id_ex_bubble), 32'h1);
        tick();
        chk("br_cnt", 32'(bus.stall_cnt), 32'h1);

        // Load-use on rt.
        bus.branch_taken = 1'b0;
        bus.id_rs_valid  = 1'b0;
        bus.id_rt_valid  = 1'b1;
        bus.id_rt        = 3'd3;
        #1;
        chk("lu_rt_stall", 32'(stall_v), 32'h07);
        tick();
        chk("lu_rt_cnt", 32'(bus.stall_cnt), 32'h2);

        // Register mismatch: no hazard.
        bus.id_rt = 3'd5;
        #1;
        chk("nomatch_stall",  32'(stall_v), 32'h1f);
        chk("nomatch_bubble", 32'(bus.id_ex_bubble), 32'h0);
        tick();

        // Matching register but EX does not write back: no hazard.
        bus.id_rt    = 3'd3;
        bus.ex_wr_en = 1'b0;
        #1;
        chk("nowr_stall",  32'(stall_v), 32'h1f);
        chk("nowr_bubble", 32'(bus.id_ex_bubble), 32'h0);
        tick();
        chk("nohaz_cnt", 32'(bus.stall_cnt), 32'h2);
        clear_inputs();

        // Single-cycle memory access.
        bus.dmem_req  = 1'b1;
        bus.dmem_done = 1'b1;
        #1;
        chk("sc_stall", 32'(stall_v), 32'h1f);
        tick();
        chk("sc_busy", 32'(bus.busy_wait), 32'h0);
        chk("sc_cnt",  32'(bus.stall_cnt), 32'h2);
        clear_inputs();

        bus.stall_cnt_clr = 1'b1;
        tick();
        chk("clr_cnt", 32'(bus.stall_cnt), 32'h0);
        bus.stall_cnt_clr = 1'b0;

        // Three-cycle memory wait.
        bus.dmem_req = 1'b1;
        #1;
        chk("w1_stall", 32'(stall_v), 32'h00);
        chk("w1_busy",  32'(bus.busy_wait), 32'h0);
        tick();
        chk("w1_busy_after", 32'(bus.busy_wait), 32'h1);
        bus.branch_taken = 1'b1;
        #1;
        chk("w2_stall", 32'(stall_v), 32'h00);
        chk("w2_flush", 32'(bus.if_id_flush), 32'h0);
        chk("w2_bubble", 32'(bus.id_ex_bubble), 32'h0);
        tick();
        bus.branch_taken = 1'b0;
        chk("w2_busy", 32'(bus.busy_wait), 32'h1);
        #1;
        chk("w3_stall", 32'(stall_v), 32'h00);
        tick();
        chk("w3_busy", 32'(bus.busy_wait), 32'h1);
        bus.dmem_done = 1'b1;
        #1;
        chk("w4_stall", 32'(stall_v), 32'h1f);
        chk("w4_busy",  32'(bus.busy_wait), 32'h1);
        tick();
        chk("w_done_busy", 32'(bus.busy_wait), 32'h0);
        chk("w_done_cnt",  32'(bus.stall_cnt), 32'h3);
        clear_inputs();

        // Timeout: memory never completes.
        bus.dmem_req = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("to_err_4", 32'(bus.err), 32'h0);
        chk("to_busy_4", 32'(bus.busy_wait), 32'h1);
        tick();
        chk("to_err_5",  32'(bus.err), 32'h1);
        chk("to_busy_5", 32'(bus.busy_wait), 32'h0);
        chk("to_cnt",    32'(bus.stall_cnt), 32'h8);
        bus.dmem_req  = 1'b0;
        bus.dmem_done = 1'b1;
        #1;
        chk("err_stall", 32'(stall_v), 32'h00);
        tick();
        chk("err_sticky", 32'(bus.err), 32'h1);
        chk("err_cnt",    32'(bus.stall_cnt), 32'h9);
        clear_inputs();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst2_err",   32'(bus.err), 32'h0);
        chk("rst2_cnt",   32'(bus.stall_cnt), 32'h0);
        chk("rst2_stall", 32'(stall_v), 32'h1f);
        rst_n = 1'b1;
        tick();
        set_load_use();
        #1;
        chk("rst2_run_lu", 32'(stall_v), 32'h07);

        // Saturation then clear-with-stall.
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        chk("sat_15", 32'(bus.stall_cnt), 32'hf);
        tick();
        tick();
        chk("sat_hold", 32'(bus.stall_cnt), 32'hf);
        bus.stall_cnt_clr = 1'b1;
        tick();
        chk("clr_prio", 32'(bus.stall_cnt), 32'h0);
        bus.stall_cnt_clr = 1'b0;
        tick();
        chk("post_clr_inc", 32'(bus.stall_cnt), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 64, maximum consecutive data-memory wait cycles before the error state.
REQ-002 Parameter CNT_W, default 16, width of the stall performance counter.
REQ-003 clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 id_rs  input  3  source register rs of the instruction in ID.
REQ-006 id_rs_valid  input  1  ID instruction reads rs.
REQ-007 id_rt  input  3  source register rt of the instruction in ID.
REQ-008 id_rt_valid  input  1  ID instruction reads rt.
REQ-009 ex_is_load  input  1  instruction in EX is a load.
REQ-010 ex_wr_en  input  1  instruction in EX writes the register file.
REQ-011 ex_wr_reg  input  3  destination register of the instruction in EX.
REQ-012 branch_taken  input  1  EX resolved a taken branch or jump this cycle.
REQ-013 dmem_req  input  1  MEM stage is accessing data memory this cycle.
REQ-014 dmem_done  input  1  data memory completes the access this cycle.
REQ-015 stall_cnt_clr  input  1  synchronous clear of stall_cnt.
REQ-016 pc_stall_n, if_id_stall_n, id_ex_stall_n, ex_mem_stall_n, mem_wb_stall_n  output  1 each  active-low hold for the PC and each pipeline register; 0 holds the register and suppresses its write enables.
REQ-017 if_id_flush  output  1  load a NOP into IF/ID.
REQ-018 id_ex_bubble  output  1  load a NOP (wr_en=0, mem_wr=0) into ID/EX.
REQ-019 busy_wait  output  1  FSM is in WAIT.
REQ-020 stall_cnt  output  CNT_W  number of cycles with any stall_n low.
REQ-021 err  output  1  sticky data-memory timeout.

Function
REQ-022 The FSM SHALL have three states: RUN, WAIT and ERR, encoded as a 2-bit register.
REQ-023 The freeze condition SHALL be defined as dmem_req & ~dmem_done, evaluated combinationally in every state.
REQ-024 During freeze, or in ERR, all five stall_n outputs SHALL be 0, and if_id_flush and id_ex_bubble SHALL be 0.
REQ-025 RUN SHALL go to WAIT on freeze; otherwise it SHALL stay in RUN.
REQ-026 WAIT SHALL go to RUN on dmem_done.
REQ-027 In WAIT, the wait counter SHALL increment each freeze cycle and SHALL be 0 in RUN.
REQ-028 When wait_cnt reaches TIMEOUT-1 with freeze still high, the FSM SHALL move to ERR and set err=1.
REQ-029 ERR SHALL be left only by reset.
REQ-030 With no freeze, branch_taken=1 SHALL drive if_id_flush=1, id_ex_bubble=1 and all stall_n=1; branch takes priority over load-use.
REQ-031 With no freeze and no branch, a load-use hazard SHALL drive pc_stall_n=0, if_id_stall_n=0, id_ex_bubble=1, and all other stall_n=1.
REQ-032 A load-use hazard SHALL be defined as ex_is_load & ex_wr_en & ((id_rs_valid & id_rs==ex_wr_reg) | (id_rt_valid & id_rt==ex_wr_reg)).
REQ-033 Otherwise all stall_n SHALL be 1 and the flush and bubble outputs SHALL be 0.
REQ-034 Single-cycle memory accesses (dmem_req & dmem_done) SHALL cause no stall and no state change.
REQ-035 stall_cnt SHALL increment by 1 on each cycle where any stall_n is 0, and SHALL saturate at all-ones.
REQ-036 stall_cnt_clr SHALL reset stall_cnt to 0 and SHALL take priority over increment in the same cycle.
REQ-037 busy_wait SHALL be a registered decode of state==WAIT, with no combinational path from inputs.

Reset
REQ-038 While rst_n=0, the block SHALL hold state=RUN, wait_cnt=0, stall_cnt=0 and err=0, with all stall_n outputs following REQ-023 to REQ-033 from the inputs.
REQ-039 Reset asserted in WAIT or ERR SHALL immediately return the block to RUN and clear err, independent of clk.

Verification
REQ-040 ex_is_load=1, ex_wr_en=1, ex_wr_reg=3, id_rs_valid=1, id_rs=3 -> pc_stall_n=0, if_id_stall_n=0, id_ex_bubble=1, mem_wb_stall_n=1, stall_cnt +1.
REQ-041 Same load-use condition plus branch_taken=1 -> if_id_flush=1, id_ex_bubble=1, all stall_n=1.
REQ-042 dmem_req=1, dmem_done=0 for 3 cycles, then dmem_done=1 -> all stall_n=0 for 3 cycles; busy_wait=1 for cycles 2-4; RUN after done; stall_cnt=3.
REQ-043 TIMEOUT=4 with dmem_req=1 and dmem_done never asserted -> err=1 after 5 edges; then rst_n pulse -> err=0, state RUN.
REQ-044 stall_cnt preloaded to all-ones by a long stall, then a further stall -> stall_cnt stays all-ones; stall_cnt_clr together with a stall -> stall_cnt=0.
